i2c_wb_arbiter: RTL

- Two-master to one-slave Wishbone arbiter with a per-access bus timeout.
- Lets the I2C-slave Wishbone master (port m0) and a host/CPU master (port m1) share one Wishbone register bus.
- Grants the bus per cycle (held while the granted master's cyc is high).
- Terminates stalled accesses with err so a hung slave cannot lock up the I2C bridge.

---
 rtl/i2c_wb_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter with a per-access stall timeout.
// Port m0 is the I2C-slave bridge and port m1 is the host CPU. The grant is
// registered and held for as long as the owner keeps cyc high. If the slave
// never answers, the access is ended with err, so a hung slave cannot lock up
// the I2C bridge.
module i2c_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int SELECT_WIDTH  = DATA_WIDTH / 8,
    parameter int ROUND_ROBIN   = 1,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // master 0 (I2C bridge)
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [SELECT_WIDTH-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    // master 1 (host)
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [SELECT_WIDTH-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    // slave side
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    // status
    output logic [1:0]              grant,
    output logic                    timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TO_VAL  = TIMEOUT_WIDTH'(TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = TIMEOUT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [1:0]               grant_q, grant_d;
    logic                     last_q, last_d;     // 0 = m0 had the bus last, 1 = m1
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    logic g0, g1;
    logic gnt_stb, gnt_cyc;
    logic timeout_w;

    assign g0 = grant_q[0];
    assign g1 = grant_q[1];

    // Slave-side request mux, steered by the registered grant
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        gnt_stb = 1'b0;
        gnt_cyc = 1'b0;
        if (g0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            gnt_stb = m0_stb_i;
            gnt_cyc = m0_cyc_i;
        end else if (g1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            gnt_stb = m1_stb_i;
            gnt_cyc = m1_cyc_i;
        end
    end

    // A stalled strobe times out when the counter reaches its limit.
    // A slave response in the same cycle takes priority over the timeout.
    always_comb begin
        timeout_w = 1'b0;
        if (TIMEOUT != 0 && state_q == BUSY && gnt_stb && cnt_q == TO_VAL
                && !s_ack_i && !s_err_i) begin
            timeout_w = 1'b1;
        end
    end

    assign timeout  = timeout_w;
    assign s_stb_o  = gnt_stb & ~timeout_w;
    assign s_cyc_o  = gnt_cyc;
    assign m0_ack_o = s_ack_i & g0;
    assign m1_ack_o = s_ack_i & g1;
    assign m0_err_o = (s_err_i | timeout_w) & g0;
    assign m1_err_o = (s_err_i | timeout_w) & g1;
    // Read data goes to both masters, and is forced to zero while no one owns the bus
    assign m0_dat_o = (|grant_q) ? s_dat_i : '0;
    assign m1_dat_o = (|grant_q) ? s_dat_i : '0;
    assign grant    = grant_q;

    // Arbitration, release and timeout-counter next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = BUSY;
                    if (ROUND_ROBIN != 0 && !last_q) begin
                        grant_d = 2'b10;
                    end else begin
                        grant_d = 2'b01;
                    end
                end else if (m0_cyc_i) begin
                    state_d = BUSY;
                    grant_d = 2'b01;
                end else if (m1_cyc_i) begin
                    state_d = BUSY;
                    grant_d = 2'b10;
                end
            end
            BUSY: begin
                // The owner dropping cyc ends its tenure, whether it finished or aborted
                if (!gnt_cyc) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = g1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        if (TIMEOUT == 0 || state_q != BUSY || !gnt_stb || s_ack_i || s_err_i
                || timeout_w) begin
            cnt_d = '0;
        end else if (cnt_q != TO_VAL) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State, grant and counter registers. After reset, last_grant points at m1,
    // so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
